// File: rtl/src_ram_loader_if.sv
// ============================================================================
// Module   : src_ram_loader_if
// Brief    : Pixel stream, source-RAM write port and lenet go/ready bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface src_ram_loader_if #(
    parameter int NPIX = 1024,
    parameter int DW   = 8
);
    localparam int AW = $clog2(NPIX);

    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          cenb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          go;
    logic          lenet_ready;
    logic [3:0]    lenet_digit;

    // master is the loader; slave is the host link / RAM / lenet environment
    modport master (
        input  s_valid, s_data, s_last, lenet_ready, lenet_digit,
        output s_ready, cenb, ab, db, go
    );

    modport slave (
        output s_valid, s_data, s_last, lenet_ready, lenet_digit,
        input  s_ready, cenb, ab, db, go
    );
endinterface

`default_nettype wire

// File: rtl/src_ram_loader.sv
// ============================================================================
// Module   : src_ram_loader
// Brief    : Fills the LeNet source-image RAM from a byte stream, starts lenet
//            and latches the classified digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module src_ram_loader #(
    parameter int NPIX    = 1024,
    parameter int DW      = 8,
    parameter int TIMEOUT = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    src_ram_loader_if.master bus,
    output logic [3:0]       digit_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             err_len_o,
    output logic             err_timeout_o,
    input  logic             err_clr_i
);
    localparam int AW = $clog2(NPIX);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] c_LAST_PIX = AW'(NPIX - 1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          s_ready_q, s_ready_d;
    logic          cenb_q, cenb_d;
    logic [AW-1:0] ab_q, ab_d;
    logic [DW-1:0] db_q, db_d;
    logic          go_q, go_d;
    logic [3:0]    digit_q, digit_d;
    logic          rv_q, rv_d;
    logic          err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d;
    logic [AW-1:0] pix_cnt_q, pix_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic w_beat;
    logic w_frame_end;
    logic w_early_last;
    logic w_in_wait;
    logic w_lenet_done;
    logic w_timeout;

    // s_ready is registered, so a beat can only be taken in IDLE/LOAD
    assign w_beat       = bus.s_valid & s_ready_q;
    assign w_frame_end  = w_beat & (pix_cnt_q == c_LAST_PIX);
    assign w_early_last = w_beat & bus.s_last & (pix_cnt_q != c_LAST_PIX);
    assign w_in_wait    = (state_q == c_WAIT);
    assign w_lenet_done = w_in_wait & bus.lenet_ready;
    assign w_timeout    = w_in_wait & ~bus.lenet_ready & (tmo_cnt_q == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_IDLE;
            s_ready_q <= 1'b0;
            cenb_q    <= 1'b1;
            ab_q      <= '0;
            db_q      <= '0;
            go_q      <= 1'b0;
            digit_q   <= 4'd0;
            rv_q      <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            pix_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            cenb_q    <= cenb_d;
            ab_q      <= ab_d;
            db_q      <= db_d;
            go_q      <= go_d;
            digit_q   <= digit_d;
            rv_q      <= rv_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            pix_cnt_q <= pix_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE, c_LOAD: begin
                if (w_frame_end) begin
                    state_d = c_START;
                end else if (w_early_last) begin
                    state_d = c_IDLE;
                end else if (w_beat) begin
                    state_d = c_LOAD;
                end
            end
            c_START: state_d = c_WAIT;
            c_WAIT: begin
                if (w_lenet_done || w_timeout) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        s_ready_d = (state_d == c_IDLE) || (state_d == c_LOAD);
        busy_o    = (state_q != c_IDLE);

        cenb_d = ~w_beat;
        ab_d   = w_beat ? pix_cnt_q : ab_q;
        db_d   = w_beat ? bus.s_data : db_q;

        pix_cnt_d = pix_cnt_q;
        if (w_frame_end || w_early_last) begin
            pix_cnt_d = '0;
        end else if (w_beat) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        // go leaves the register one cycle after the final write lands
        go_d      = (state_q == c_START);
        tmo_cnt_d = w_in_wait ? tmo_cnt_q + 1'b1 : '0;

        digit_d = w_lenet_done ? bus.lenet_digit : digit_q;
        rv_d    = w_lenet_done;

        // a new error outranks a coincident clear
        err_len_d = w_early_last | (w_frame_end & ~bus.s_last) | (err_len_q & ~err_clr_i);
        err_tmo_d = w_timeout | (err_tmo_q & ~err_clr_i);
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.cenb       = cenb_q;
    assign bus.ab         = ab_q;
    assign bus.db         = db_q;
    assign bus.go         = go_q;
    assign digit_o        = digit_q;
    assign result_valid_o = rv_q;
    assign err_len_o      = err_len_q;
    assign err_timeout_o  = err_tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_src_ram_loader.sv
// ============================================================================
// Module   : tb_src_ram_loader
// Brief    : Directed/random frames against a frame-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_src_ram_loader;
    localparam int NPIX    = 1024;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [3:0] digit;
    logic       result_valid, busy, err_len, err_timeout;

    src_ram_loader_if #(.NPIX(NPIX), .DW(8)) bus ();

    src_ram_loader #(.NPIX(NPIX), .DW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .digit_o        (digit),
        .result_valid_o (result_valid),
        .busy_o         (busy),
        .err_len_o      (err_len),
        .err_timeout_o  (err_timeout),
        .err_clr_i      (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, in frame terms
    int         cyc = 0;
    int         exp_pix = 0;
    int         go_at = -1;
    bit         waiting = 1'b0;
    bit         exp_sready = 1'b0;
    logic [3:0] exp_digit = 4'd0;
    bit         exp_err_len = 1'b0;
    bit         exp_err_tmo = 1'b0;
    int         n_wr = 0, n_go = 0, n_rv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: sample inputs, advance the model, compare outputs #1 after the edge
    task automatic cycle();
        bit rs, clr, acc, lst, rdy, in_wait, set_len, set_tmo, exp_wr, exp_rv, exp_go;
        logic [7:0] d;
        logic [3:0] ldg;
        int c0, waddr;
        rs  = rst;
        clr = err_clr;
        acc = bus.s_valid && exp_sready;
        d   = bus.s_data;
        lst = bus.s_last;
        rdy = bus.lenet_ready;
        ldg = bus.lenet_digit;
        c0  = cyc;
        @(posedge clk);
        #1;
        cyc++;
        exp_wr = 0; exp_rv = 0; set_len = 0; set_tmo = 0; waddr = 0;
        if (rs) begin
            exp_pix = 0; waiting = 0; go_at = -1; exp_digit = 4'd0;
            exp_err_len = 0; exp_err_tmo = 0;
        end else begin
            in_wait = waiting && go_at >= 0 && c0 >= go_at;
            if (in_wait && rdy) begin
                exp_rv = 1; exp_digit = ldg; waiting = 0; go_at = -1;
            end else if (in_wait && c0 == go_at + TIMEOUT - 1) begin
                set_tmo = 1; waiting = 0; go_at = -1;
            end
            if (acc) begin
                exp_wr = 1;
                waddr  = exp_pix;
                if (exp_pix == NPIX - 1) begin
                    set_len = !lst; exp_pix = 0; waiting = 1; go_at = c0 + 2;
                end else if (lst) begin
                    set_len = 1; exp_pix = 0;
                end else begin
                    exp_pix++;
                end
            end
            if (clr) begin exp_err_len = 0; exp_err_tmo = 0; end
            if (set_len) exp_err_len = 1;
            if (set_tmo) exp_err_tmo = 1;
        end
        exp_go     = (go_at >= 0 && cyc == go_at);
        exp_sready = !rs && !waiting;

        chk("cenb", 32'(bus.cenb), 32'(!exp_wr));
        if (exp_wr) begin
            chk("ab", 32'(bus.ab), 32'(waddr));
            chk("db", 32'(bus.db), 32'(d));
        end
        chk("go", 32'(bus.go), 32'(exp_go));
        chk("result_valid", 32'(result_valid), 32'(exp_rv));
        chk("digit", 32'(digit), 32'(exp_digit));
        chk("busy", 32'(busy), 32'((exp_pix != 0) || waiting));
        chk("s_ready", 32'(bus.s_ready), 32'(exp_sready));
        chk("err_len", 32'(err_len), 32'(exp_err_len));
        chk("err_timeout", 32'(err_timeout), 32'(exp_err_tmo));
        if (bus.cenb === 1'b0) n_wr++;
        if (bus.go === 1'b1) n_go++;
        if (result_valid === 1'b1) n_rv++;
    endtask

    // mode 0: back-to-back, data=i; 1: valid every other cycle; 2: ~70% valid
    task automatic send_frame(input int nbeats, input int last_idx, input int mode,
                              input bit clr_on_last, input int rst_at);
        int i = 0;
        bit v, acc, aborted = 0;
        for (int k = 0; k < 5000 && i < nbeats; k++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            bus.s_valid = v;
            bus.s_data  = (mode == 0) ? i[7:0] : 8'($urandom);
            bus.s_last  = (i == last_idx);
            err_clr     = clr_on_last && (i == last_idx);
            rst         = (i == rst_at);
            if (rst) bus.s_valid = 1'b1;
            acc = bus.s_valid && exp_sready;
            cycle();
            if (rst) begin
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (acc) i++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        err_clr     = 1'b0;
        if (!aborted) chk("frame_beats", 32'(i), 32'(nbeats));
    endtask

    task automatic lenet(input int delay, input logic [3:0] dg, input bit respond);
        for (int k = 0; k < 8 && bus.go !== 1'b1; k++) cycle();
        chk("go_seen", 32'(bus.go), 32'd1);
        if (respond) begin
            repeat (delay) cycle();
            bus.lenet_ready = 1'b1;
            bus.lenet_digit = dg;
            cycle();
            bus.lenet_ready = 1'b0;
            bus.lenet_digit = 4'($urandom);
            chk("rv_pulse", 32'(result_valid), 32'd1);
            chk("digit_result", 32'(digit), 32'(dg));
        end else begin
            repeat (TIMEOUT) cycle();
            chk("timeout_flag", 32'(err_timeout), 32'd1);
        end
        repeat (3) cycle();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, g0, r0;
        logic [3:0] dg;
        bus.s_valid = 1'b1; bus.s_data = 8'hA5; bus.s_last = 1'b0;
        bus.lenet_ready = 1'b0; bus.lenet_digit = 4'd9;

        // reset with a valid beat pending: nothing written, all outputs idle
        repeat (3) cycle();
        chk("rst_cenb", 32'(bus.cenb), 32'd1);
        chk("rst_go", 32'(bus.go), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        bus.s_valid = 1'b0;
        rst = 1'b0;
        repeat (2) cycle();

        // 1: full frame, ready 50 cycles after go with digit 7
        w0 = n_wr; g0 = n_go; r0 = n_rv;
        send_frame(NPIX, NPIX - 1, 0, 0, -1);
        lenet(50, 4'd7, 1);
        chk("t1_writes", 32'(n_wr - w0), 32'd1024);
        chk("t1_go_count", 32'(n_go - g0), 32'd1);
        chk("t1_rv_count", 32'(n_rv - r0), 32'd1);
        chk("t1_digit", 32'(digit), 32'd7);
        chk("t1_err_len", 32'(err_len), 32'd0);

        // 2: gappy valid, random data, ready on the last allowed WAIT cycle
        w0 = n_wr;
        dg = 4'($urandom);
        send_frame(NPIX, NPIX - 1, 1, 0, -1);
        lenet(TIMEOUT - 1, dg, 1);
        chk("t2_writes", 32'(n_wr - w0), 32'd1024);
        chk("t2_no_timeout", 32'(err_timeout), 32'd0);

        // 3: early s_last on beat 99, then clear, then a normal frame from ab=0
        w0 = n_wr; g0 = n_go;
        send_frame(100, 99, 2, 0, -1);
        repeat (20) cycle();
        chk("t3_writes", 32'(n_wr - w0), 32'd100);
        chk("t3_no_go", 32'(n_go - g0), 32'd0);
        chk("t3_err_len", 32'(err_len), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);
        pulse_clr();
        chk("t3_err_clr", 32'(err_len), 32'd0);
        send_frame(NPIX, NPIX - 1, 2, 0, -1);
        lenet($urandom_range(1, TIMEOUT - 2), 4'($urandom), 1);

        // clear coincident with a fresh length error: error wins
        send_frame(5, 4, 0, 1, -1);
        chk("t3_clr_vs_set", 32'(err_len), 32'd1);
        pulse_clr();

        // 4: full frame without s_last still launches
        g0 = n_go; r0 = n_rv;
        send_frame(NPIX, -1, 0, 0, -1);
        lenet(10, 4'd3, 1);
        chk("t4_err_len", 32'(err_len), 32'd1);
        chk("t4_go_count", 32'(n_go - g0), 32'd1);
        chk("t4_rv_count", 32'(n_rv - r0), 32'd1);
        pulse_clr();

        // 5: lenet never answers
        r0 = n_rv;
        send_frame(NPIX, NPIX - 1, 0, 0, -1);
        lenet(0, 4'd0, 0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_digit_kept", 32'(digit), 32'd3);
        chk("t5_no_result", 32'(n_rv - r0), 32'd0);
        pulse_clr();
        chk("t5_err_clr", 32'(err_timeout), 32'd0);

        // 6: reset at beat 500 aborts the frame, then a fresh frame completes
        w0 = n_wr; g0 = n_go;
        send_frame(NPIX, NPIX - 1, 0, 0, 500);
        chk("t6_rst_cenb", 32'(bus.cenb), 32'd1);
        chk("t6_rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("t6_rst_digit", 32'(digit), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        repeat (20) cycle();
        chk("t6_partial_writes", 32'(n_wr - w0), 32'd500);
        chk("t6_no_go", 32'(n_go - g0), 32'd0);
        w0 = n_wr;
        send_frame(NPIX, NPIX - 1, 2, 0, -1);
        lenet(20, 4'd5, 1);
        chk("t6_writes", 32'(n_wr - w0), 32'd1024);
        chk("t6_digit", 32'(digit), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
